sine_lut: RTL and testbench

Registered 256-entry sine lookup table that converts the top byte of a 32-bit phase-accumulator word into an 8-bit unsigned, offset-binary sine sample. It sits between an NCO/phase accumulator and a DAC or PWM stage in the waveform-generation path. One sample is produced per enabled clock cycle, with one cycle of latency.

---
 rtl/sine_lut.sv | 77 +++++++
 tb/tb_sine_lut.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sine_lut.sv
// sine_lut: registered 256-entry sine ROM, phase[31:24] -> offset-binary 8-bit sample.
// Only the first quarter-wave magnitude is stored. The second quarter is mirrored,
// and the negative half is formed as 128 - magnitude. The quarter-wave is stored as
// an offset from mid-scale, 0..127. With this scheme, entry[i] + entry[i+128] == 256
// holds exactly.
module sine_lut (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] phase,
    output logic [7:0]  sine
);

    logic [7:0] idx;
    logic [6:0] half_pos;   // position inside the current half period, 0..127
    logic [6:0] qtr_pos;    // folded into the first quarter, 0..64
    logic [6:0] mag;        // |sample - 128|, 0..127
    logic [7:0] sine_d;
    logic [7:0] sine_q;

    assign idx      = phase[31:24];
    assign half_pos = idx[6:0];

    // Fold the second quarter (65..127) back onto 63..1. The value 128 - k wraps into 7 bits as -k.
    always_comb begin
        qtr_pos = half_pos;
        if (half_pos[6] && (half_pos[5:0] != 6'd0))
            qtr_pos = 7'd0 - half_pos;
    end

    // Quarter-wave magnitude ROM: round(127*sin(2*pi*k/256)) for k = 0..64.
    always_comb begin
        mag = 7'd0;
        case (qtr_pos)
            7'd0:  mag = 7'd0;    7'd1:  mag = 7'd3;    7'd2:  mag = 7'd6;
            7'd3:  mag = 7'd9;    7'd4:  mag = 7'd12;   7'd5:  mag = 7'd16;
            7'd6:  mag = 7'd19;   7'd7:  mag = 7'd22;   7'd8:  mag = 7'd25;
            7'd9:  mag = 7'd28;   7'd10: mag = 7'd31;   7'd11: mag = 7'd34;
            7'd12: mag = 7'd37;   7'd13: mag = 7'd40;   7'd14: mag = 7'd43;
            7'd15: mag = 7'd46;   7'd16: mag = 7'd49;   7'd17: mag = 7'd51;
            7'd18: mag = 7'd54;   7'd19: mag = 7'd57;   7'd20: mag = 7'd60;
            7'd21: mag = 7'd63;   7'd22: mag = 7'd65;   7'd23: mag = 7'd68;
            7'd24: mag = 7'd71;   7'd25: mag = 7'd73;   7'd26: mag = 7'd76;
            7'd27: mag = 7'd78;   7'd28: mag = 7'd81;   7'd29: mag = 7'd83;
            7'd30: mag = 7'd85;   7'd31: mag = 7'd88;   7'd32: mag = 7'd90;
            7'd33: mag = 7'd92;   7'd34: mag = 7'd94;   7'd35: mag = 7'd96;
            7'd36: mag = 7'd98;   7'd37: mag = 7'd100;  7'd38: mag = 7'd102;
            7'd39: mag = 7'd104;  7'd40: mag = 7'd106;  7'd41: mag = 7'd107;
            7'd42: mag = 7'd109;  7'd43: mag = 7'd111;  7'd44: mag = 7'd112;
            7'd45: mag = 7'd113;  7'd46: mag = 7'd115;  7'd47: mag = 7'd116;
            7'd48: mag = 7'd117;  7'd49: mag = 7'd118;  7'd50: mag = 7'd120;
            7'd51: mag = 7'd121;  7'd52: mag = 7'd122;  7'd53: mag = 7'd122;
            7'd54: mag = 7'd123;  7'd55: mag = 7'd124;  7'd56: mag = 7'd125;
            7'd57: mag = 7'd125;  7'd58: mag = 7'd126;  7'd59: mag = 7'd126;
            7'd60: mag = 7'd126;  7'd61: mag = 7'd127;  7'd62: mag = 7'd127;
            7'd63: mag = 7'd127;  7'd64: mag = 7'd127;
            default: mag = 7'd0;
        endcase
    end

    // Next sample: reset to mid-scale, load on enable, otherwise hold.
    always_comb begin
        sine_d = sine_q;
        if (reset)
            sine_d = 8'd128;
        else if (enable)
            sine_d = idx[7] ? (8'd128 - {1'b0, mag}) : (8'd128 + {1'b0, mag});
    end

    // Output register. This keeps any combinational path from phase to sine out of the design.
    always_ff @(posedge clk) begin
        sine_q <= sine_d;
    end

    assign sine = sine_q;

endmodule

// File: tb/tb_sine_lut.sv
// Scoreboard bench for sine_lut. The driver pushes the hand-computed expected sample
// for each edge it sets up. The monitor pops that sample and compares it just after
// the edge.
module tb_sine_lut;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] phase = 32'h0;
    logic [7:0]  sine;

    always #10 clk = ~clk;

    sine_lut dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .phase  (phase),
        .sine   (sine)
    );

    typedef struct {
        logic [7:0] exp;
        int         tag;
        string      name;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passes = 0;
    logic [7:0] obs [256];

    // Full reference table, entry[i] = round(128 + 127*sin(2*pi*i/256)).
    logic [7:0] tbl [256] = '{
        128,131,134,137,140,144,147,150,153,156,159,162,165,168,171,174,
        177,179,182,185,188,191,193,196,199,201,204,206,209,211,213,216,
        218,220,222,224,226,228,230,232,234,235,237,239,240,241,243,244,
        245,246,248,249,250,250,251,252,253,253,254,254,254,255,255,255,
        255,255,255,255,254,254,254,253,253,252,251,250,250,249,248,246,
        245,244,243,241,240,239,237,235,234,232,230,228,226,224,222,220,
        218,216,213,211,209,206,204,201,199,196,193,191,188,185,182,179,
        177,174,171,168,165,162,159,156,153,150,147,144,140,137,134,131,
        128,125,122,119,116,112,109,106,103,100, 97, 94, 91, 88, 85, 82,
         79, 77, 74, 71, 68, 65, 63, 60, 57, 55, 52, 50, 47, 45, 43, 40,
         38, 36, 34, 32, 30, 28, 26, 24, 22, 21, 19, 17, 16, 15, 13, 12,
         11, 10,  8,  7,  6,  6,  5,  4,  3,  3,  2,  2,  2,  1,  1,  1,
          1,  1,  1,  1,  2,  2,  2,  3,  3,  4,  5,  6,  6,  7,  8, 10,
         11, 12, 13, 15, 16, 17, 19, 21, 22, 24, 26, 28, 30, 32, 34, 36,
         38, 40, 43, 45, 47, 50, 52, 55, 57, 60, 63, 65, 68, 71, 74, 77,
         79, 82, 85, 88, 91, 94, 97,100,103,106,109,112,116,119,122,125
    };

    // Drive inputs at the falling edge, then queue the expected sample for the next rising edge.
    task automatic step(input logic r, input logic e, input logic [31:0] ph,
                        input logic [7:0] x, input int tag, input string nm);
        @(negedge clk);
        reset  = r;
        enable = e;
        phase  = ph;
        q.push_back('{exp: x, tag: tag, name: nm});
    endtask

    // Monitor: compare the registered output shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (sine === e.exp) passes++;
                else $display("FAIL %s: sine=%0d expected %0d", e.name, sine, e.exp);
                if (e.tag >= 0) obs[e.tag] = sine;
            end
        end
    end

    initial begin
        int lo;
        int hi;
        int wait_cyc;
        for (int i = 0; i < 256; i++) obs[i] = 8'd0;

        // Reset with enable high and idx 64 present. The output must stay at mid-scale.
        step(1'b1, 1'b1, 32'h4000_0000, 8'd128, -1, "reset_edge1");
        step(1'b1, 1'b1, 32'h4000_0000, 8'd128, -1, "reset_edge2");
        step(1'b0, 1'b1, 32'h4000_0000, 8'd255, -1, "post_reset");

        // Full sweep, one index per clock.
        for (int i = 0; i < 256; i++)
            step(1'b0, 1'b1, {8'(i), 24'h0}, tbl[i], i, "sweep");

        // Wrap 255 -> 0.
        step(1'b0, 1'b1, 32'hFF00_0000, 8'd125, -1, "wrap_255");
        step(1'b0, 1'b1, 32'h0000_0000, 8'd128, -1, "wrap_0");

        // The low 24 phase bits are ignored.
        step(1'b0, 1'b1, 32'h20FF_FFFF, 8'd218, -1, "lowbits_ff");
        step(1'b0, 1'b1, 32'h2000_0000, 8'd218, -1, "lowbits_00");
        step(1'b0, 1'b1, 32'hC012_3456, 8'd1,   -1, "lowbits_c0");

        // Only the phase value at the edge counts. A mid-cycle change replaces idx 64 with 32.
        step(1'b0, 1'b1, 32'h4000_0000, 8'd218, -1, "midcycle_change");
        #5 phase = 32'h2000_0000;

        // Enable hold: load 255, then sweep the phase with enable low.
        step(1'b0, 1'b1, 32'h4000_0000, 8'd255, -1, "hold_load");
        for (int i = 0; i < 256; i++)
            step(1'b0, 1'b0, {8'(i), 24'hABCDEF}, 8'd255, -1, "hold");
        step(1'b0, 1'b1, 32'hC000_0000, 8'd1, -1, "reenable");

        // Reset takes priority over enable.
        step(1'b1, 1'b1, 32'h4000_0000, 8'd128, -1, "reset_priority");
        step(1'b1, 1'b0, 32'h4000_0000, 8'd128, -1, "reset_no_en");
        step(1'b0, 1'b1, 32'h1000_0000, 8'd177, -1, "after_reset_16");
        step(1'b0, 1'b1, 32'hA000_0000, 8'd38,  -1, "idx_160");

        // Drain the scoreboard with a bounded wait.
        @(negedge clk);
        enable = 1'b0;
        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d entries pending, required 0", q.size());
        end

        // Check odd symmetry and range using the samples captured during the sweep.
        lo = 255;
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            if (int'(obs[i]) < lo) lo = int'(obs[i]);
            if (int'(obs[i]) > hi) hi = int'(obs[i]);
        end
        for (int i = 0; i < 128; i++) begin
            checks++;
            if (int'(obs[i]) + int'(obs[i+128]) == 256) passes++;
            else $display("FAIL symmetry[%0d]: sum=%0d required 256", i,
                          int'(obs[i]) + int'(obs[i+128]));
        end
        checks++;
        if (lo == 1) passes++;
        else $display("FAIL sweep_min: got %0d required 1", lo);
        checks++;
        if (hi == 255) passes++;
        else $display("FAIL sweep_max: got %0d required 255", hi);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
